cdb_arbiter: RTL and testbench

- Execution decision unit that shares the single common data bus (CDB) between the issue/execute stages: ALU, multiplier, divider and load/store.
- Each stage holds its result with valid asserted until it is granted. The arbiter grants one stage per cycle through that stage's canGo input, using round-robin priority.
- The granted result is captured into a registered CDB slot, which drives the ROB and the reservation-station broadcast.
- Backpressure comes from the ROB via cdbReady_i.

---
 rtl/ooo_exec_pkg.sv | 24 ++
 rtl/cdb_arbiter_if.sv | 30 +++
 rtl/rr_pick_onehot.sv | 35 +++
 rtl/cdb_arbiter.sv | 126 ++++++++++++
 tb/tb_cdb_arbiter.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/ooo_exec_pkg.sv
// Types and constants shared by the out-of-order execute cluster and its CDB arbiter.
// The packet fields are sized for the largest legal configuration; users cast them down to their own widths.
package ooo_exec_pkg;

    localparam int DATA_W    = 64;
    localparam int FLAGS_W   = 4;

    localparam int UNIT_ALU  = 0;
    localparam int UNIT_MULT = 1;
    localparam int UNIT_DIV  = 2;
    localparam int UNIT_LS   = 3;

    // Wide enough for a 255-entry ROB and for 8 requesting units.
    localparam int CDB_TAG_W = 8;
    localparam int CDB_SRC_W = 3;

    typedef struct packed {
        logic [CDB_TAG_W-1:0] tag;
        logic [DATA_W-1:0]    val;
        logic [FLAGS_W-1:0]   flags;
        logic [CDB_SRC_W-1:0] src;
    } cdb_pkt_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Execute-stage request bus and registered CDB slot outputs.
// The master modport belongs to the execute stages and the ROB; the slave modport belongs to the arbiter.
interface cdb_arbiter_if #(
    parameter int NUM_UNITS  = 4,
    parameter int ROBsizeLog = 5,
    parameter int SRC_W      = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) ();
    logic [NUM_UNITS-1:0]                       valid_i;
    logic [NUM_UNITS*ROBsizeLog-1:0]            tag_i;
    logic [NUM_UNITS*ooo_exec_pkg::DATA_W-1:0]  val_i;
    logic [NUM_UNITS*ooo_exec_pkg::FLAGS_W-1:0] flags_i;
    logic [NUM_UNITS-1:0]                       canGo_o;
    logic                                       cdbReady_i;
    logic                                       flush_i;
    logic                                       cdb_valid_o;
    logic [ROBsizeLog-1:0]                      cdb_tag_o;
    logic [ooo_exec_pkg::DATA_W-1:0]            cdb_val_o;
    logic [ooo_exec_pkg::FLAGS_W-1:0]           cdb_flags_o;
    logic [SRC_W-1:0]                           cdb_src_o;

    modport master (
        output valid_i, tag_i, val_i, flags_i, cdbReady_i, flush_i,
        input  canGo_o, cdb_valid_o, cdb_tag_o, cdb_val_o, cdb_flags_o, cdb_src_o
    );

    modport slave (
        input  valid_i, tag_i, val_i, flags_i, cdbReady_i, flush_i,
        output canGo_o, cdb_valid_o, cdb_tag_o, cdb_val_o, cdb_flags_o, cdb_src_o
    );
endinterface

// File: rtl/rr_pick_onehot.sv
// Round-robin pick: rotate req so ptr lands at bit 0, take the lowest set bit, and map it back to a unit index.
// Purely combinational; also suitable for reservation-station issue select.
module rr_pick_onehot #(
    parameter int NUM_UNITS = 4,
    parameter int IDX_W     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic [NUM_UNITS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_UNITS-1:0] gnt,
    output logic [IDX_W-1:0]     idx
);

    logic [NUM_UNITS-1:0] rot;
    logic [IDX_W:0]       sum;

    assign rot = NUM_UNITS'({req, req} >> ptr);

    always_comb begin
        gnt = '0;
        idx = '0;
        sum = '0;
        // Descending scan so the lowest set rotated bit is the one that sticks.
        for (int j = NUM_UNITS - 1; j >= 0; j--) begin
            if (rot[j]) begin
                sum = {1'b0, ptr} + (IDX_W+1)'(j);
                if (sum >= (IDX_W+1)'(NUM_UNITS)) begin
                    sum = sum - (IDX_W+1)'(NUM_UNITS);
                end
                idx = sum[IDX_W-1:0];
            end
        end
        gnt[idx] = |rot;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that shares the common data bus between execute stages; one registered CDB slot.
// Latency 1 cycle from valid_i to cdb_valid_o; slot drains and refills on the same edge when cdbReady_i is high.
// Backpressure: no grant while the slot is full and cdbReady_i is low. CDB_ARBITER_STATS_EN adds grant/stall counters.
module cdb_arbiter
    import ooo_exec_pkg::*;
#(
    parameter int NUM_UNITS  = 4,
    parameter int ROBsize    = 16,
    parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
    input  logic clk_i,
    input  logic reset_ni,
    cdb_arbiter_if.slave bus
`ifdef CDB_ARBITER_STATS_EN
    ,
    output logic [NUM_UNITS*16-1:0] grant_cnt_o,
    output logic [15:0]             stall_cnt_o
`endif
);

    localparam int SRC_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic                  slot_free;
    logic                  grant;
    logic [NUM_UNITS-1:0]  pick_gnt;
    logic [SRC_W-1:0]      pick_idx;
    logic [SRC_W-1:0]      rr_q, rr_d;
    logic                  cdb_valid_q, cdb_valid_d;
    cdb_pkt_t              pkt_q, pkt_d;
    logic [ROBsizeLog-1:0] tag_sel;
    logic [DATA_W-1:0]     val_sel;
    logic [FLAGS_W-1:0]    flags_sel;

    rr_pick_onehot #(.NUM_UNITS(NUM_UNITS), .IDX_W(SRC_W)) u_pick (
        .req (bus.valid_i),
        .ptr (rr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign slot_free   = ~cdb_valid_q | bus.cdbReady_i;
    assign grant       = reset_ni & slot_free & ~bus.flush_i & (|bus.valid_i);
    assign bus.canGo_o = grant ? pick_gnt : '0;

    // Grant is one-hot, so an AND-OR mux selects the winner's payload.
    always_comb begin
        tag_sel   = '0;
        val_sel   = '0;
        flags_sel = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (pick_gnt[k]) begin
                tag_sel   = tag_sel   | bus.tag_i[k*ROBsizeLog +: ROBsizeLog];
                val_sel   = val_sel   | bus.val_i[k*DATA_W +: DATA_W];
                flags_sel = flags_sel | bus.flags_i[k*FLAGS_W +: FLAGS_W];
            end
        end
    end

    always_comb begin
        rr_d        = rr_q;
        cdb_valid_d = cdb_valid_q;
        pkt_d       = pkt_q;
        if (bus.flush_i) begin
            cdb_valid_d = 1'b0;
        end else if (grant) begin
            pkt_d.tag   = CDB_TAG_W'(tag_sel);
            pkt_d.val   = val_sel;
            pkt_d.flags = flags_sel;
            pkt_d.src   = CDB_SRC_W'(pick_idx);
            cdb_valid_d = 1'b1;
            rr_d        = (pick_idx == SRC_W'(NUM_UNITS - 1)) ? '0 : pick_idx + 1'b1;
        end else if (bus.cdbReady_i) begin
            cdb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rr_q        <= '0;
            cdb_valid_q <= 1'b0;
            pkt_q       <= '0;
        end else begin
            rr_q        <= rr_d;
            cdb_valid_q <= cdb_valid_d;
            pkt_q       <= pkt_d;
        end
    end

    assign bus.cdb_valid_o = cdb_valid_q;
    assign bus.cdb_tag_o   = ROBsizeLog'(pkt_q.tag);
    assign bus.cdb_val_o   = pkt_q.val;
    assign bus.cdb_flags_o = pkt_q.flags;
    assign bus.cdb_src_o   = SRC_W'(pkt_q.src);

`ifdef CDB_ARBITER_STATS_EN
    logic [NUM_UNITS*16-1:0] grant_cnt_q, grant_cnt_d;
    logic [15:0]             stall_cnt_q, stall_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        stall_cnt_d = stall_cnt_q;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (bus.canGo_o[k] && grant_cnt_q[k*16 +: 16] != 16'hFFFF) begin
                grant_cnt_d[k*16 +: 16] = grant_cnt_q[k*16 +: 16] + 16'd1;
            end
        end
        if ((|bus.valid_i) && !slot_free && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign grant_cnt_o = grant_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, round-robin order, backpressure, flush, single requester, async reset.
module tb_cdb_arbiter;
    import ooo_exec_pkg::*;

    logic clk_i = 1'b0;
    logic reset_ni;
    always #5 clk_i = ~clk_i;

    cdb_arbiter_if #(.NUM_UNITS(4), .ROBsizeLog(5)) bus ();

`ifdef CDB_ARBITER_STATS_EN
    logic [63:0] grant_cnt;
    logic [15:0] stall_cnt;
`endif

    cdb_arbiter #(.NUM_UNITS(4), .ROBsize(16)) dut (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .bus      (bus)
`ifdef CDB_ARBITER_STATS_EN
        ,
        .grant_cnt_o (grant_cnt),
        .stall_cnt_o (stall_cnt)
`endif
    );

    typedef struct {
        logic [3:0] v;
        logic       rdy;
        logic       fl;
        logic [3:0] go;
        logic       cv;
        logic [1:0] src;
        logic [4:0] tag;
    } vec_t;

    localparam int NV = 21;
    vec_t tbl [NV];

    logic [4:0]  unit_tag   [4];
    logic [63:0] unit_val   [4];
    logic [3:0]  unit_flags [4];

    int tests = 0;
    int fails = 0;

    function automatic vec_t mk(logic [3:0] v, logic rdy, logic fl, logic [3:0] go,
                                logic cv, logic [1:0] src, logic [4:0] tag);
        vec_t r;
        r.v = v; r.rdy = rdy; r.fl = fl; r.go = go; r.cv = cv; r.src = src; r.tag = tag;
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 time units");
        $fatal(1);
    end

    initial begin
        unit_tag[UNIT_ALU]  = 5'd5;  unit_val[UNIT_ALU]  = 64'h1111;        unit_flags[UNIT_ALU]  = 4'd1;
        unit_tag[UNIT_MULT] = 5'd9;  unit_val[UNIT_MULT] = 64'h2222;        unit_flags[UNIT_MULT] = 4'd2;
        unit_tag[UNIT_DIV]  = 5'd7;  unit_val[UNIT_DIV]  = 64'hDEAD_BEEF;   unit_flags[UNIT_DIV]  = 4'd3;
        unit_tag[UNIT_LS]   = 5'd12; unit_val[UNIT_LS]   = 64'h4444;        unit_flags[UNIT_LS]   = 4'd4;

        //            valid   rdy   flush go       cv    src    tag
        tbl[0]  = mk(4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 5'd5);
        tbl[1]  = mk(4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 5'd9);
        tbl[2]  = mk(4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2, 5'd7);
        tbl[3]  = mk(4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3, 5'd12);
        tbl[4]  = mk(4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 5'd5);
        tbl[5]  = mk(4'b0010, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 5'd5);
        tbl[6]  = mk(4'b0010, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 5'd5);
        tbl[7]  = mk(4'b0010, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 5'd5);
        tbl[8]  = mk(4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 5'd9);
        tbl[9]  = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd1, 5'd9);
        tbl[10] = mk(4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 5'd7);
        tbl[11] = mk(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 5'd7);
        tbl[12] = mk(4'b0001, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd2, 5'd7);
        tbl[13] = mk(4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 5'd5);
        tbl[14] = mk(4'b1001, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3, 5'd12);
        tbl[15] = mk(4'b1001, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 5'd5);
        tbl[16] = mk(4'b0101, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2, 5'd7);
        tbl[17] = mk(4'b0101, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 5'd5);
        tbl[18] = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 5'd5);
        tbl[19] = mk(4'b0010, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 5'd5);
        tbl[20] = mk(4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 5'd9);

        bus.tag_i   = {unit_tag[3], unit_tag[2], unit_tag[1], unit_tag[0]};
        bus.val_i   = {unit_val[3], unit_val[2], unit_val[1], unit_val[0]};
        bus.flags_i = {unit_flags[3], unit_flags[2], unit_flags[1], unit_flags[0]};

        // Reset held with every unit requesting.
        reset_ni       = 1'b0;
        bus.valid_i    = 4'b1111;
        bus.cdbReady_i = 1'b1;
        bus.flush_i    = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset canGo", 64'(bus.canGo_o), 64'd0);
        chk("reset cdb_valid", 64'(bus.cdb_valid_o), 64'd0);
        chk("reset cdb_tag", 64'(bus.cdb_tag_o), 64'd0);
        chk("reset cdb_val", bus.cdb_val_o, 64'd0);
        chk("reset cdb_src", 64'(bus.cdb_src_o), 64'd0);
`ifdef CDB_ARBITER_STATS_EN
        chk("reset grant_cnt", grant_cnt, 64'd0);
        chk("reset stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        @(negedge clk_i);
        reset_ni = 1'b1;
        #1;
        chk("release canGo", 64'(bus.canGo_o), 64'b0001);
        @(posedge clk_i);
        #1;
        chk("release cdb_valid", 64'(bus.cdb_valid_o), 64'd1);
        chk("release cdb_src", 64'(bus.cdb_src_o), 64'd0);

        // Fresh start for the table: slot empty, pointer at unit 0.
        @(negedge clk_i);
        reset_ni       = 1'b0;
        bus.valid_i    = 4'b0000;
        bus.cdbReady_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_ni = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk_i);
            bus.valid_i    = tbl[i].v;
            bus.cdbReady_i = tbl[i].rdy;
            bus.flush_i    = tbl[i].fl;
            #1;
            chk($sformatf("row%0d canGo", i), 64'(bus.canGo_o), 64'(tbl[i].go));
            @(posedge clk_i);
            #1;
            chk($sformatf("row%0d cdb_valid", i), 64'(bus.cdb_valid_o), 64'(tbl[i].cv));
            chk($sformatf("row%0d cdb_src", i), 64'(bus.cdb_src_o), 64'(tbl[i].src));
            chk($sformatf("row%0d cdb_tag", i), 64'(bus.cdb_tag_o), 64'(tbl[i].tag));
            chk($sformatf("row%0d cdb_val", i), bus.cdb_val_o, unit_val[tbl[i].src]);
            chk($sformatf("row%0d cdb_flags", i), 64'(bus.cdb_flags_o), 64'(unit_flags[tbl[i].src]));
        end

        // Async reset between edges while the slot is full (mult result loaded by the last row).
        @(posedge clk_i);
        #3;
        reset_ni = 1'b0;
        #1;
        chk("async cdb_valid", 64'(bus.cdb_valid_o), 64'd0);
        chk("async canGo", 64'(bus.canGo_o), 64'd0);
        chk("async cdb_tag", 64'(bus.cdb_tag_o), 64'd0);
`ifdef CDB_ARBITER_STATS_EN
        chk("async grant_cnt", grant_cnt, 64'd0);
        chk("async stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        @(negedge clk_i);
        reset_ni       = 1'b1;
        bus.valid_i    = 4'b1111;
        bus.cdbReady_i = 1'b1;
        bus.flush_i    = 1'b0;
        #1;
        chk("post-async canGo", 64'(bus.canGo_o), 64'b0001);
        @(posedge clk_i);
        #1;
        chk("post-async cdb_valid", 64'(bus.cdb_valid_o), 64'd1);
        chk("post-async cdb_src", 64'(bus.cdb_src_o), 64'd0);
        chk("post-async cdb_tag", 64'(bus.cdb_tag_o), 64'(unit_tag[UNIT_ALU]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
